dec_pulse_seq: RTL and testbench
================================

Name: dec_pulse_seq

Overview:
- Sequenced 3-to-8 decoder; the receive-side counterpart to the team's 8-to-3 enable-gated OR encoder.
- Accepts encoded indices over a valid/ready handshake and drives the matching one-hot output line for a fixed number of cycles.
- An optional idle gap follows each pulse.
- Sits downstream of the encoder path; drives select/strobe lines that must never have two bits high at once.

Parameters:
W, 3, index width; output width N = 2**W
PULSE_LEN, 4, cycles each one-hot output is held high (>=1)
GAP, 1, idle cycles with y=0 after each pulse (>=0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; low aborts the current pulse and blocks new ones
in_valid  input  1  in_idx valid
in_idx  input  W  encoded index to decode
in_ready  output  1  holding register can accept this cycle
y  output  N  registered one-hot decoded output, all-zero when idle
done  output  1  high in the last cycle of each completed pulse
busy  output  1  FSM not IDLE or holding register full

Behaviour:
- Reset (async, rst_n=0), effective immediately without clk:
  - y=0, state=IDLE, hold empty, counter=0.
  - done=0, busy=0, in_ready=1.
- Holding register: one entry (hold_idx, hold_full).
  - load = FSM takes hold this cycle (defined below).
  - in_ready = !hold_full | load. This is combinational from registers only; it never depends on in_valid.
  - Accept = in_valid & in_ready at the rising edge; writes hold_idx and sets hold_full.
  - Simultaneous load and accept: hold is replaced, hold_full stays 1.
- FSM states: IDLE, PULSE, GAP. Counter cnt is wide enough for max(PULSE_LEN,GAP)-1.
  - IDLE: load = hold_full & en. On load: state->PULSE, cnt=PULSE_LEN-1, y<=onehot(hold_idx).
  - PULSE:
    - If en=0: state->IDLE, y<=0, no done. hold is untouched.
    - Else if cnt!=0: cnt--, y holds.
    - Else (cnt==0): done=1 this cycle.
      - GAP>0: state->GAP, cnt=GAP-1, y<=0.
      - GAP==0 and hold_full: load; y<=onehot(hold_idx), cnt=PULSE_LEN-1. Back-to-back pulses with no zero cycle.
      - Otherwise: state->IDLE, y<=0.
  - GAP: y=0.
    - If en=0: state->IDLE.
    - Else if cnt!=0: cnt--.
    - Else: state->IDLE.
  - Cycle spacing: with GAP>0, consecutive pulses are separated by exactly GAP zero cycles plus 1 IDLE cycle. Implementations must not shortcut GAP->PULSE.
- Latency: index accepted at edge T0 with FSM in IDLE → y is one-hot from edge T0+1 to edge T0+1+PULSE_LEN.
- done = (state==PULSE) & (cnt==0) & en. Combinational from registers; a single-cycle pulse per completed pulse.
- busy = (state!=IDLE) | hold_full.
- Invariants:
  - popcount(y) <= 1 in every cycle.
  - y changes only on clk edges or on async reset.
- en=0 while IDLE: hold may still fill via the handshake; no pulse starts until en=1.

Decomposition:
- Shared package: state enum (IDLE/PULSE/GAP), localparam N = 2**W, counter-width function clog2.
- One natural sub-module: dec_onehot (pure combinational W-to-2**W decoder). It is instanced once and feeds the y register.
- Holding register and FSM stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> y=8'h00, in_ready=1, busy=0, done=0; no accept during reset.
2. Single pulse (PULSE_LEN=4, GAP=1, en=1): in_idx=5 valid for one edge T0 -> y=8'h20 in cycles T0+1..T0+4, done=1 only in T0+4, y=0 from T0+5, busy=0 at T0+7.
3. Back-to-back: in_idx=3 then 6, in_valid held high:
   - 3 is accepted at T0; 6 is accepted at T0+1, the same edge 3 loads.
   - in_ready=0 until the hold drains.
   - y=8'h08 for 4 cycles, 0 for 2 cycles (GAP + IDLE), then 8'h40 for 4 cycles.
4. Enable abort: start idx=2, drop en in the 2nd pulse cycle:
   - y=0 from the next edge, no done.
   - A queued idx=7 waits in hold.
   - When en returns to 1, y=8'h80 for 4 cycles.
5. Async reset mid-pulse: assert rst_n=0 between clock edges while y=8'h10 -> y=0, busy=0 immediately (before the next clk); hold cleared.
6. GAP=0 build: idx 1 and 2 queued -> y=8'h02 for 4 cycles then immediately 8'h04 for 4 cycles; done high in cycles 4 and 8; popcount(y)<=1 throughout.

Source files
------------

// File: rtl/dec_pulse_seq_pkg.sv
// Shared types and elaboration helpers for the sequenced 3-to-8 pulse decoder.
// Contents:
//   state_e    - FSM state encoding (idle / pulse / gap)
//   clog2      - ceiling log2 for elaboration-time width math
//   out_width  - decoded output width N = 2**W
//   cnt_width  - counter width able to hold max(PULSE_LEN, GAP) - 1
package dec_pulse_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_e;

    localparam int unsigned DefaultW = 3;
    localparam int unsigned DefaultN = 2 ** DefaultW;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned out_width(input int unsigned w);
        return 2 ** w;
    endfunction

    // At least one bit so the counter is never a zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned pulse_len,
                                              input int unsigned gap);
        int unsigned m;
        int unsigned r;
        m = (pulse_len > gap) ? pulse_len : gap;
        r = clog2(m);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Pure combinational W-to-2**W one-hot decoder.
// Ports:
//   i_idx [W-1:0]    - encoded index
//   o_y   [2**W-1:0] - one-hot image of i_idx (exactly one bit set)
module dec_onehot #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0]      i_idx,
    output logic [2**W-1:0]   o_y
);

    always_comb begin
        o_y        = '0;
        o_y[i_idx] = 1'b1;
    end

endmodule

// File: rtl/dec_pulse_seq.sv
// Sequenced decoder: accepts encoded indices over valid/ready into a one-entry
// holding register, then drives the matching one-hot line for PULSE_LEN cycles
// followed by GAP idle cycles. y is registered and never has two bits high.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   en        - enable; low aborts the running pulse and blocks new ones
//   in_valid  - in_idx valid
//   in_idx    - encoded index
//   in_ready  - holding register can accept this cycle
//   y         - registered one-hot output, zero when idle
//   done      - high in the last cycle of each completed pulse
//   busy      - FSM not idle or holding register full
module dec_pulse_seq
    import dec_pulse_seq_pkg::*;
#(
    parameter int unsigned W         = 3,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [W-1:0]      in_idx,
    output logic              in_ready,
    output logic [2**W-1:0]   y,
    output logic              done,
    output logic              busy
);

    localparam int unsigned N  = out_width(W);
    localparam int unsigned CW = cnt_width(PULSE_LEN, GAP);

    localparam logic [CW-1:0] PulseInit = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GapInit   = CW'((GAP == 0) ? 0 : GAP - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [N-1:0]    r_y;
    logic [N-1:0]    w_y_next;
    logic [W-1:0]    r_hold_idx;
    logic            r_hold_full;
    logic            w_load;
    logic            w_accept;
    logic [N-1:0]    w_onehot;

    dec_onehot #(
        .W (W)
    ) u_dec_onehot (
        .i_idx (r_hold_idx),
        .o_y   (w_onehot)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_y_next     = r_y;
        w_load       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_y_next = '0;
                if (r_hold_full && en) begin
                    w_load       = 1'b1;
                    w_state_next = StPulse;
                    w_cnt_next   = PulseInit;
                    w_y_next     = w_onehot;
                end
            end
            StPulse: begin
                if (!en) begin
                    w_state_next = StIdle;
                    w_y_next     = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else if (GAP != 0) begin
                    w_state_next = StGap;
                    w_cnt_next   = GapInit;
                    w_y_next     = '0;
                end else if (r_hold_full) begin
                    // No gap configured: chain straight into the next pulse.
                    w_load     = 1'b1;
                    w_cnt_next = PulseInit;
                    w_y_next   = w_onehot;
                end else begin
                    w_state_next = StIdle;
                    w_y_next     = '0;
                end
            end
            StGap: begin
                w_y_next = '0;
                // Always return through idle so pulses are spaced GAP + 1 cycles.
                if (!en) begin
                    w_state_next = StIdle;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_y_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_y     <= w_y_next;
        end
    end

    // A new index may land in the same edge the FSM drains the old one.
    assign in_ready = !r_hold_full || w_load;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_idx  <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_idx  <= in_idx;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    assign y    = r_y;
    assign done = (r_state == StPulse) && (r_cnt == '0) && en;
    assign busy = (r_state != StIdle) || r_hold_full;

endmodule

// File: tb/tb_dec_pulse_seq.sv
// Directed bench for dec_pulse_seq: one GAP=1 instance plus one GAP=0 instance.
module tb_dec_pulse_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_valid2;
    logic [2:0] in_idx;
    logic       in_ready, done, busy;
    logic       in_ready2, done2, busy2;
    logic [7:0] y, y2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dec_pulse_seq #(
        .W         (3),
        .PULSE_LEN (4),
        .GAP       (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid),
        .in_idx   (in_idx),
        .in_ready (in_ready),
        .y        (y),
        .done     (done),
        .busy     (busy)
    );

    dec_pulse_seq #(
        .W         (3),
        .PULSE_LEN (4),
        .GAP       (0)
    ) dut_g0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid2),
        .in_idx   (in_idx),
        .in_ready (in_ready2),
        .y        (y2),
        .done     (done2),
        .busy     (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b1;
        in_valid2 = 1'b1;
        in_idx    = 3'd5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++;
            if (y !== 8'h00) $display("FAIL reset_y k=%0d got %h want 00", k, y);
            else n_pass++;
            n_total++;
            if ({in_ready, busy, done} !== 3'b100)
                $display("FAIL reset_flags k=%0d got rdy/busy/done=%b want 100", k,
                         {in_ready, busy, done});
            else n_pass++;
        end
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        rst_n     = 1'b1;
        tick();
        n_total++;
        if ({busy, busy2, y, y2} !== 18'h0)
            $display("FAIL reset_no_accept got busy=%b busy2=%b y=%h y2=%h want all 0",
                     busy, busy2, y, y2);
        else n_pass++;
    endtask

    task automatic test_single;
        logic [7:0] exp_y;
        in_idx   = 3'd5;
        in_valid = 1'b1;
        tick();                                 // T0: accept
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_t0 got %b want 1", busy);
        else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_y = (k <= 4) ? 8'h20 : 8'h00;
            n_total++;
            if (y !== exp_y) $display("FAIL single_y k=%0d got %h want %h", k, y, exp_y);
            else n_pass++;
            n_total++;
            if (done !== (k == 4))
                $display("FAIL single_done k=%0d got %b want %b", k, done, (k == 4));
            else n_pass++;
            if (k == 5 || k >= 6) begin
                n_total++;
                if (busy !== (k == 5))
                    $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k == 5));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_y;
        in_idx   = 3'd3;
        in_valid = 1'b1;
        tick();                                 // T0: accept 3
        in_idx = 3'd6;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_t0 got %b want 1", in_ready);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 4)       exp_y = 8'h08;
            else if (k <= 6)  exp_y = 8'h00;
            else if (k <= 10) exp_y = 8'h40;
            else              exp_y = 8'h00;
            n_total++;
            if (y !== exp_y) $display("FAIL b2b_y k=%0d got %h want %h", k, y, exp_y);
            else n_pass++;
            n_total++;
            if (done !== (k == 4 || k == 10))
                $display("FAIL b2b_done k=%0d got %b want %b", k, done, (k == 4 || k == 10));
            else n_pass++;
            n_total++;
            if (in_ready !== !(k <= 5))
                $display("FAIL b2b_ready k=%0d got %b want %b", k, in_ready, !(k <= 5));
            else n_pass++;
            n_total++;
            if ($countones(y) > 1) $display("FAIL b2b_onehot k=%0d got %h want <=1 bit", k, y);
            else n_pass++;
            if (k == 5) in_valid = 1'b0;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_enable_abort;
        in_idx   = 3'd2;
        in_valid = 1'b1;
        tick();                                 // accept 2
        in_idx = 3'd7;
        tick();                                 // load 2, accept 7
        in_valid = 1'b0;
        n_total++;
        if (y !== 8'h04) $display("FAIL abort_y1 got %h want 04", y);
        else n_pass++;
        tick();                                 // 2nd pulse cycle
        en = 1'b0;
        n_total++;
        if (done !== 1'b0) $display("FAIL abort_done_en0 got %b want 0", done);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++;
            if ({y, done, busy, in_ready} !== {8'h00, 3'b010})
                $display("FAIL abort_held k=%0d got y=%h done=%b busy=%b rdy=%b want 00/0/1/0",
                         k, y, done, busy, in_ready);
            else n_pass++;
        end
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_total++;
            if (y !== ((k <= 4) ? 8'h80 : 8'h00))
                $display("FAIL abort_resume_y k=%0d got %h want %h", k, y,
                         ((k <= 4) ? 8'h80 : 8'h00));
            else n_pass++;
            n_total++;
            if (done !== (k == 4))
                $display("FAIL abort_resume_done k=%0d got %b want %b", k, done, (k == 4));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        in_idx   = 3'd4;
        in_valid = 1'b1;
        tick();                                 // accept 4
        in_idx = 3'd6;
        tick();                                 // load 4, accept 6
        in_valid = 1'b0;
        n_total++;
        if ({y, busy} !== {8'h10, 1'b1}) $display("FAIL arst_pre got y=%h busy=%b want 10/1", y, busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({y, busy, in_ready, done} !== {8'h00, 3'b010})
            $display("FAIL arst_immediate got y=%h busy=%b rdy=%b done=%b want 00/0/1/0",
                     y, busy, in_ready, done);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++;
            if ({y, busy} !== 9'h0)
                $display("FAIL arst_hold_cleared k=%0d got y=%h busy=%b want 00/0", k, y, busy);
            else n_pass++;
        end
    endtask

    task automatic test_gap0;
        logic [7:0] exp_y;
        in_idx    = 3'd1;
        in_valid2 = 1'b1;
        tick();                                 // accept 1
        in_idx = 3'd2;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) in_valid2 = 1'b0;
            if (k <= 4)      exp_y = 8'h02;
            else if (k <= 8) exp_y = 8'h04;
            else             exp_y = 8'h00;
            n_total++;
            if (y2 !== exp_y) $display("FAIL gap0_y k=%0d got %h want %h", k, y2, exp_y);
            else n_pass++;
            n_total++;
            if (done2 !== (k == 4 || k == 8))
                $display("FAIL gap0_done k=%0d got %b want %b", k, done2, (k == 4 || k == 8));
            else n_pass++;
            n_total++;
            if ($countones(y2) > 1) $display("FAIL gap0_onehot k=%0d got %h want <=1 bit", k, y2);
            else n_pass++;
        end
        n_total++;
        if (busy2 !== 1'b0) $display("FAIL gap0_idle got busy=%b want 0", busy2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_abort();
        test_async_reset();
        test_gap0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
